// File: rtl/key_fetch_pkg.sv
// Shared types and defaults for the key-ROM fetch engine.
// Holds the FSM state encoding and the default parameter widths.
package key_fetch_pkg;

  localparam int ADDR_BITS_D  = 5;
  localparam int DATA_WIDTH_D = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/key_fetch.sv
// Fetches a burst of key words from a registered key ROM and presents
// them one at a time on a valid/ready port.
//
// Ports:
//   clk, rst             rising-edge clock, sync active-high reset
//   req_valid/req_ready  burst request handshake
//   req_idx, req_cnt     first ROM index, key count minus one
//   rom_en, rom_addr     key ROM read strobe and address
//   rom_data             ROM read data, one-cycle latency
//   key_valid/key_ready  key output handshake
//   key_data, key_last   fetched key, final-key-of-burst flag
//   busy                 high whenever a burst is in progress
module key_fetch
  import key_fetch_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_BITS-1:0]  req_idx,
  input  logic [ADDR_BITS-1:0]  req_cnt,
  output logic                  rom_en,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic [DATA_WIDTH-1:0] key_data,
  output logic                  key_last,
  output logic                  busy
);

  state_t state, state_nx;

  logic [ADDR_BITS-1:0]  cur_addr;
  logic [ADDR_BITS-1:0]  remaining;
  logic [DATA_WIDTH-1:0] key_q;
  logic                  accept;
  logic                  advance;
  logic                  last;

  assign last     = (remaining == '0);
  assign rom_addr = cur_addr;
  assign key_data = key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // All outputs decode from registered state only, so neither
  // rom_data nor key_ready reaches an output combinationally.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rom_en    = 1'b0;
    key_valid = 1'b0;
    key_last  = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        rom_en   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        state_nx = HOLD;
      end
      HOLD: begin
        key_valid = 1'b1;
        key_last  = last;
        if (key_ready) begin
          if (last) begin
            state_nx = IDLE;
          end else begin
            advance  = 1'b1;
            state_nx = ISSUE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Address increment wraps naturally at 2^ADDR_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      key_q     <= '0;
    end else begin
      if (accept) begin
        cur_addr  <= req_idx;
        remaining <= req_cnt;
      end
      if (advance) begin
        cur_addr  <= cur_addr + ADDR_BITS'(1);
        remaining <= remaining - ADDR_BITS'(1);
      end
      if (state == WAIT) begin
        key_q <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_key_fetch.sv
// Directed self-checking bench for key_fetch with a registered
// key-ROM model and an expected-key scoreboard.
module tb_key_fetch;
  import key_fetch_pkg::*;

  localparam int AW = 5;
  localparam int DW = 128;
  localparam int W1 = DW + 1;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] req_cnt;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          key_valid;
  logic          key_ready;
  logic [DW-1:0] key_data;
  logic          key_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  logic [DW:0]   sb[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wrap_a[3];

  key_fetch #(
    .ADDR_BITS (AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_idx  (req_idx),
    .req_cnt  (req_cnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_data (key_data),
    .key_last (key_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] key_of(input logic [AW-1:0] a);
    case (a)
      5'd0:    return 128'hf69f2445df4f9b17ad2b417be66c3710;
      5'd2:    return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      5'd4:    return 128'h603deb1015ca71be2b73aef0857d7781;
      5'd30:   return 128'h7b0c785e27e8ad3f8223207104725dd4;
      5'd31:   return 128'h6bc1bee22e409f96e93d7e117393172a;
      default: return {96'hdeadbeef_0badcafe_13572468, 27'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    rom_data <= rom_en ? key_of(rom_addr) : '0;
    if (rom_en) rd_log.push_back(rom_addr);
  end

  task automatic chk(input string tag,
                     input logic [DW:0] obs,
                     input logic [DW:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [AW-1:0] idx,
                         input logic [AW-1:0] cnt);
    req_valid = 1'b1;
    req_idx   = idx;
    req_cnt   = cnt;
    for (int k = 0; k <= int'(cnt); k++)
      sb.push_back({k == int'(cnt), key_of(idx + AW'(k))});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_key(input string tag, output int cyc);
    logic [DW:0] e;
    cyc = 0;
    while (!key_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, W1'(key_valid), W1'(1));
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    chk(tag, {key_last, key_data}, e);
  endtask

  initial begin
    wrap_a    = '{5'd30, 5'd31, 5'd0};
    rst       = 1'b1;
    req_valid = 1'b0;
    req_idx   = '0;
    req_cnt   = '0;
    key_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rom_en", W1'(rom_en), W1'(0));
    chk("rst_addr", W1'(rom_addr), W1'(0));
    chk("rst_kvalid", W1'(key_valid), W1'(0));
    chk("rst_klast", W1'(key_last), W1'(0));
    chk("rst_busy", W1'(busy), W1'(0));
    chk("rst_ready", W1'(req_ready), W1'(1));
    chk("rst_kdata", W1'(key_data), W1'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", W1'(req_ready), W1'(1));

    // single fetch
    key_ready = 1'b1;
    request(5'd2, 5'd0);
    chk("t1_busy", W1'(busy), W1'(1));
    chk("t1_rom_en", W1'(rom_en), W1'(1));
    chk("t1_addr", W1'(rom_addr), W1'(2));
    get_key("t1_key", n);
    chk("t1_lat", W1'(n), W1'(2));
    @(negedge clk);
    chk("t1_vdrop", W1'(key_valid), W1'(0));
    chk("t1_idle", W1'(busy), W1'(0));

    // wrap burst
    rd_log.delete();
    request(5'd30, 5'd2);
    get_key("t2_k0", n);
    @(negedge clk);
    get_key("t2_k1", n);
    chk("t2_gap1", W1'(n), W1'(2));
    @(negedge clk);
    get_key("t2_k2", n);
    chk("t2_gap2", W1'(n), W1'(2));
    @(negedge clk);
    chk("t2_idle", W1'(busy), W1'(0));
    chk("t2_nrd", W1'(rd_log.size()), W1'(3));
    for (int i = 0; i < 3 && i < rd_log.size(); i++)
      chk("t2_rdaddr", W1'(rd_log[i]), W1'(wrap_a[i]));

    // backpressure
    key_ready = 1'b0;
    request(5'd4, 5'd0);
    get_key("t3_key", n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_v", W1'(key_valid), W1'(1));
      chk("t3_hold_d", W1'(key_data), W1'(key_of(5'd4)));
      chk("t3_hold_l", W1'(key_last), W1'(1));
      chk("t3_rom_en", W1'(rom_en), W1'(0));
      @(negedge clk);
    end
    chk("t3_still_v", W1'(key_valid), W1'(1));
    key_ready = 1'b1;
    @(negedge clk);
    chk("t3_vdrop", W1'(key_valid), W1'(0));
    chk("t3_idle", W1'(busy), W1'(0));

    // request while busy
    rd_log.delete();
    request(5'd1, 5'd0);
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = 5'd9;
    req_cnt   = 5'd0;
    chk("t4_ready", W1'(req_ready), W1'(0));
    @(negedge clk);
    req_valid = 1'b0;
    get_key("t4_key", n);
    repeat (3) @(negedge clk);
    chk("t4_idle", W1'(busy), W1'(0));
    chk("t4_kv", W1'(key_valid), W1'(0));
    chk("t4_nrd", W1'(rd_log.size()), W1'(1));
    if (rd_log.size() > 0)
      chk("t4_rdaddr", W1'(rd_log[0]), W1'(1));
    chk("t4_sb", W1'(sb.size()), W1'(0));

    // reset mid-burst
    request(5'd10, 5'd5);
    get_key("t5_k0", n);
    @(negedge clk);
    get_key("t5_k1", n);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_kv", W1'(key_valid), W1'(0));
    chk("t5_rom_en", W1'(rom_en), W1'(0));
    chk("t5_busy", W1'(busy), W1'(0));
    chk("t5_ready", W1'(req_ready), W1'(1));
    chk("t5_addr", W1'(rom_addr), W1'(0));
    chk("t5_kdata", W1'(key_data), W1'(0));
    rst = 1'b0;
    sb.delete();
    rd_log.delete();
    repeat (4) @(negedge clk);
    chk("t5_nokey", W1'(key_valid), W1'(0));
    chk("t5_nord", W1'(rd_log.size()), W1'(0));
    request(5'd5, 5'd1);
    get_key("t5_n0", n);
    chk("t5_lat", W1'(n), W1'(2));
    @(negedge clk);
    get_key("t5_n1", n);
    @(negedge clk);
    chk("t5_idle", W1'(busy), W1'(0));
    chk("t5_sb", W1'(sb.size()), W1'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
